fetch_mt: RTL and testbench
===========================

# fetch_mt

Multi-thread instruction/data fetch unit for the CPU core. It accepts independent read or write requests from a parametrised number of hardware threads and arbitrates them round-robin onto a single shared W-bus master port, with one transaction outstanding at a time. Each thread gets its own completion strobe, and an optional error strobe. It replaces the fixed 4-thread FETCH front end and sits between the thread schedulers and the system bus.

## Interface
Parameters:
- THREADS, 4, number of requesting threads (≥2)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, bus-wait cycles before abort (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  single clock for the core and bus side
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  THREADS  per-thread request; held until that thread's ack_o
- we_i  in  THREADS  per-thread write mode (1 = write, 0 = read)
- addr_i  in  THREADS*AW  packed addresses; thread t at [t*AW +: AW]
- data_i  in  THREADS*DW  packed write data; thread t at [t*DW +: DW]
- data_o  out  DW  read data, valid while any ack_o bit is high
- ack_o  out  THREADS  one-cycle completion pulse, one-hot
- err_o  out  THREADS  one-cycle abort pulse, coincident with ack_o
- grant_o  out  $clog2(THREADS)  id of the thread currently owning the bus
- W_STB  out  1  bus cycle valid
- W_WRITE  out  1  bus write enable
- W_ADDR  out  AW  bus address
- W_DATA_O  out  DW  bus write data
- W_ACK  in  1  bus completion
- W_DATA_I  in  DW  bus read data, sampled on W_ACK

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any req_i is set, pick a winner round-robin, searching from (last_grant+1) mod THREADS upward. Register grant_o, W_ADDR, W_DATA_O and W_WRITE from the winner, set W_STB=1, and go to BUS. If no req_i is set, stay in IDLE.
- BUS: hold all W_* outputs stable. When W_ACK=1: clear W_STB, capture W_DATA_I into data_o (reads only; data_o is unchanged on writes), set ack_o[grant]=1, and go to RESP.
- RESP: ack_o is high for exactly this one cycle, then the FSM returns to IDLE. The pointer update last_grant=grant_o happens on the RESP→IDLE transition.
- A requester must drop req_i on the edge that ends its ack_o cycle. If req_i is still high in the following IDLE cycle, it is treated as a new request.
- Deasserting req_i during BUS does not abort the bus cycle; the transaction completes and acks normally.
- W_ACK outside BUS is ignored.
- An asynchronous reset mid-transaction immediately drops W_STB and ack_o and returns the FSM to IDLE.
- The round-robin pointer wraps from THREADS-1 to 0.
- If only one thread requests, it wins every arbitration.

## Timing
- Reset values: W_STB=0, W_WRITE=0, W_ADDR=0, W_DATA_O=0, data_o=0, ack_o=0, err_o=0, grant_o=0, last_grant=THREADS-1 (so thread 0 has first priority), FSM state IDLE.
- If req_i is seen at edge N, W_STB is high from N.
- If W_ACK is sampled high at edge N+k (k≥1), ack_o is high during cycle N+k to N+k+1.
- Minimum turnaround per transaction is 3 cycles (zero-wait bus).
- Back-to-back service to a different thread: its W_STB rises at the edge after RESP.
- All outputs are registered; there is no combinational path from req_i or W_ACK to any output.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) runs in BUS and clears on entry to BUS.
  - When it reaches TIMEOUT with no W_ACK: W_STB drops, data_o=0, ack_o[grant]=1 and err_o[grant]=1 for the RESP cycle, then IDLE.
  - W_ACK on the same edge as expiry wins: normal completion, no error.
- FETCH_TIMEOUT_EN undefined: BUS waits indefinitely and err_o is tied to 0.

## Structure
- Package fetch_pkg holds the FSM state enum (IDLE, BUS, RESP) and the thread-id width helper.
- Sub-module rr_arbiter: parametrised by THREADS; inputs req and last_grant, outputs a one-hot grant and its encoded id. Purely combinational, registered in fetch_mt.

## Test plan
- Single read: reset, req_i=4'b0001, addr=0x100, W_ACK after 2 wait cycles with W_DATA_I=0xDEADBEEF -> W_ADDR=0x100, W_WRITE=0; ack_o=4'b0001 for one cycle with data_o=0xDEADBEEF.
- Write: thread 2, we=1, addr=0x40, data=0x1234 -> W_WRITE=1, W_DATA_O=0x1234, grant_o=2; ack_o=4'b0100, data_o unchanged.
- Fairness: all four threads hold req, zero-wait bus -> grant order 0,1,2,3,0; each ack spaced 3 cycles apart.
- Wrap-around: THREADS=3, last grant 2, requests from 0 and 2 -> thread 0 served next.
- Reset mid-BUS: assert rst_n=0 while W_STB=1 -> W_STB=0 immediately, no ack_o; after release, the pending req is served from thread 0 priority.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT=8): W_ACK never asserted -> after 8 cycles ack_o and err_o pulse together for the granted thread, data_o=0; W_ACK landing on the expiry edge -> normal ack, err_o=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and thread-id width helper for fetch_mt.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_mt_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1.
module rr_arbiter
    import fetch_pkg::*;
#(
    parameter int THREADS = 4,
    localparam int IW = id_w(THREADS)
) (
    input  logic [THREADS-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [THREADS-1:0] gnt,
    output logic [IW-1:0]      gnt_id
);

    // Walk from farthest to nearest so the closest requester overwrites the rest.
    always_comb begin
        gnt_id = '0;
        for (int i = THREADS; i >= 1; i--) begin
            if (req[IW'((int'(last_grant) + i) % THREADS)]) begin
                gnt_id = IW'((int'(last_grant) + i) % THREADS);
            end
        end
        gnt = '0;
        gnt[gnt_id] = |req;
    end

endmodule

// File: rtl/fetch_mt.sv
// fetch_mt: multi-thread fetch unit, round-robin arbitration onto one W-bus master.
// Define FETCH_TIMEOUT_EN to abort bus cycles after TIMEOUT wait cycles with err_o.
module fetch_mt
    import fetch_pkg::*;
#(
    parameter int THREADS = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [THREADS-1:0]    req_i,
    input  logic [THREADS-1:0]    we_i,
    input  logic [THREADS*AW-1:0] addr_i,
    input  logic [THREADS*DW-1:0] data_i,
    output logic [DW-1:0]         data_o,
    output logic [THREADS-1:0]    ack_o,
    output logic [THREADS-1:0]    err_o,
    output logic [id_w(THREADS)-1:0] grant_o,
    output logic                  W_STB,
    output logic                  W_WRITE,
    output logic [AW-1:0]         W_ADDR,
    output logic [DW-1:0]         W_DATA_O,
    input  logic                  W_ACK,
    input  logic [DW-1:0]         W_DATA_I
);

    localparam int IW = id_w(THREADS);

    if (THREADS < 2) begin : g_bad_threads
        $error("THREADS must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    state_t state_q, state_d;
    logic [IW-1:0] grant_q, grant_d, last_q, last_d, win_id;
    logic [THREADS-1:0] win, ack_q, ack_d;
    logic stb_q, stb_d, write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [THREADS-1:0][AW-1:0] addr_a;
    logic [THREADS-1:0][DW-1:0] data_a;

    assign addr_a = addr_i;
    assign data_a = data_i;

    rr_arbiter #(.THREADS(THREADS)) u_arb (
        .req        (req_i),
        .last_grant (last_q),
        .gnt        (win),
        .gnt_id     (win_id)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [THREADS-1:0] err_q, err_d;
    logic expire;
    // Expiry fires on the edge where the count would reach TIMEOUT.
    assign expire = cnt_q == CW'(TIMEOUT - 1);
    assign err_o  = err_q;
`else
    assign err_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        stb_d   = stb_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
`ifdef FETCH_TIMEOUT_EN
        err_d   = '0;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: if (|win) begin
                state_d = BUS;
                grant_d = win_id;
                stb_d   = 1'b1;
                write_d = we_i[win_id];
                addr_d  = addr_a[win_id];
                wdata_d = data_a[win_id];
`ifdef FETCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            BUS: if (W_ACK) begin
                state_d        = RESP;
                stb_d          = 1'b0;
                ack_d[grant_q] = 1'b1;
                rdata_d        = write_q ? rdata_q : W_DATA_I;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (expire) begin
                state_d        = RESP;
                stb_d          = 1'b0;
                ack_d[grant_q] = 1'b1;
                err_d[grant_q] = 1'b1;
                rdata_d        = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
`endif
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(THREADS - 1);
            stb_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            stb_q   <= stb_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
`ifdef FETCH_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign data_o   = rdata_q;
    assign ack_o    = ack_q;
    assign grant_o  = grant_q;
    assign W_STB    = stb_q;
    assign W_WRITE  = write_q;
    assign W_ADDR   = addr_q;
    assign W_DATA_O = wdata_q;

endmodule

// File: tb/tb_fetch_mt.sv
// tb_fetch_mt: directed self-checking bench for fetch_mt (4-thread and 3-thread instances).
module tb_fetch_mt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0]   req, we, ack, err;
    logic [127:0] addr, wdata;
    logic [31:0]  rdata, bus_addr, bus_wdata, bus_rdata;
    logic [1:0]   grant;
    logic         stb, bus_we, bus_ack;

    fetch_mt #(.THREADS(4), .AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
        .data_o(rdata), .ack_o(ack), .err_o(err), .grant_o(grant),
        .W_STB(stb), .W_WRITE(bus_we), .W_ADDR(bus_addr), .W_DATA_O(bus_wdata),
        .W_ACK(bus_ack), .W_DATA_I(bus_rdata)
    );

    logic [2:0]  req3, we3, ack3, err3;
    logic [47:0] addr3, wdata3;
    logic [15:0] rdata3, bus_addr3, bus_wdata3;
    logic [1:0]  grant3;
    logic        stb3, bus_we3, bus_ack3;

    fetch_mt #(.THREADS(3), .AW(16), .DW(16), .TIMEOUT(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .we_i(we3), .addr_i(addr3), .data_i(wdata3),
        .data_o(rdata3), .ack_o(ack3), .err_o(err3), .grant_o(grant3),
        .W_STB(stb3), .W_WRITE(bus_we3), .W_ADDR(bus_addr3), .W_DATA_O(bus_wdata3),
        .W_ACK(bus_ack3), .W_DATA_I(16'h5a5a)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0; we = '0; addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0; bus_ack3 = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({stb, bus_we, bus_addr, bus_wdata} !== 66'd0) begin errors++; $display("FAIL reset_bus: got stb=%b we=%b addr=%h wd=%h, expected all 0", stb, bus_we, bus_addr, bus_wdata); end
        checks++; if ({rdata, ack, err, grant} !== 42'd0) begin errors++; $display("FAIL reset_out: got data=%h ack=%b err=%b grant=%0d, expected all 0", rdata, ack, err, grant); end
        bus_ack = 1'b1;
        tick();
        checks++; if ({stb, ack} !== 5'd0) begin errors++; $display("FAIL idle_wack_ignored: got stb=%b ack=%b, expected 0 0", stb, ack); end
        bus_ack = 1'b0;
    endtask

    task automatic test_single_read();
        req = 4'b0001; we = 4'b0000; addr[31:0] = 32'h100;
        tick();
        checks++; if ({stb, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h100}) begin errors++; $display("FAIL read_issue: got stb=%b we=%b addr=%h, expected 1 0 00000100", stb, bus_we, bus_addr); end
        tick();
        tick();
        checks++; if ({stb, ack, bus_addr} !== {1'b1, 4'b0000, 32'h100}) begin errors++; $display("FAIL read_wait: got stb=%b ack=%b addr=%h, expected 1 0000 00000100", stb, ack, bus_addr); end
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        checks++; if ({stb, ack, rdata} !== {1'b0, 4'b0001, 32'hDEADBEEF}) begin errors++; $display("FAIL read_ack: got stb=%b ack=%b data=%h, expected 0 0001 deadbeef", stb, ack, rdata); end
        req = '0; bus_ack = 1'b0; bus_rdata = 32'h0;
        tick();
        checks++; if ({stb, ack} !== 5'd0) begin errors++; $display("FAIL read_ack_pulse: got stb=%b ack=%b, expected 0 0000", stb, ack); end
    endtask

    task automatic test_write();
        req = 4'b0100; we = 4'b0100; addr[95:64] = 32'h40; wdata[95:64] = 32'h1234;
        tick();
        checks++; if ({stb, bus_we, bus_addr, bus_wdata, grant} !== {1'b1, 1'b1, 32'h40, 32'h1234, 2'd2}) begin errors++; $display("FAIL write_issue: got stb=%b we=%b addr=%h wd=%h grant=%0d, expected 1 1 00000040 00001234 2", stb, bus_we, bus_addr, bus_wdata, grant); end
        bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
        tick();
        checks++; if ({ack, rdata} !== {4'b0100, 32'hDEADBEEF}) begin errors++; $display("FAIL write_ack: got ack=%b data=%h, expected 0100 deadbeef", ack, rdata); end
        req = '0; we = '0; bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 4; t++) addr[t*32 +: 32] = 32'h1000 + t;
        bus_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus_rdata = 32'hA0 + k;
            tick();
            checks++; if ({stb, grant, bus_addr} !== {1'b1, 2'(k % 4), 32'h1000 + 32'(k % 4)}) begin errors++; $display("FAIL rr_grant%0d: got stb=%b grant=%0d addr=%h, expected 1 %0d %h", k, stb, grant, bus_addr, k % 4, 32'h1000 + (k % 4)); end
            tick();
            checks++; if ({ack, rdata} !== {4'(1 << (k % 4)), 32'hA0 + 32'(k)}) begin errors++; $display("FAIL rr_ack%0d: got ack=%b data=%h, expected %b %h", k, ack, rdata, 4'(1 << (k % 4)), 32'hA0 + k); end
            if (k == 4) begin req = '0; bus_ack = 1'b0; end
            tick();
            checks++; if ({stb, ack} !== 5'd0) begin errors++; $display("FAIL rr_resp%0d: got stb=%b ack=%b, expected 0 0000", k, stb, ack); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req3 = 3'b100; bus_ack3 = 1'b1;
        tick();
        checks++; if (grant3 !== 2'd2) begin errors++; $display("FAIL wrap_first: got grant=%0d, expected 2", grant3); end
        tick();
        req3 = 3'b000;
        tick();
        req3 = 3'b101;
        tick();
        checks++; if ({stb3, grant3} !== {1'b1, 2'd0}) begin errors++; $display("FAIL wrap_grant: got stb=%b grant=%0d, expected 1 0", stb3, grant3); end
        tick();
        checks++; if ({ack3, rdata3} !== {3'b001, 16'h5a5a}) begin errors++; $display("FAIL wrap_ack: got ack=%b data=%h, expected 001 5a5a", ack3, rdata3); end
        req3 = 3'b100;
        tick();
        tick();
        checks++; if (grant3 !== 2'd2) begin errors++; $display("FAIL wrap_next: got grant=%0d, expected 2", grant3); end
        tick();
        req3 = '0; bus_ack3 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_bus();
        do_reset();
        req = 4'b0010; bus_ack = 1'b1;
        tick();
        tick();
        req = 4'b0000; bus_ack = 1'b0;
        tick();
        req = 4'b0110;
        tick();
        checks++; if ({stb, grant} !== {1'b1, 2'd2}) begin errors++; $display("FAIL mid_pre: got stb=%b grant=%0d, expected 1 2", stb, grant); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({stb, ack, grant} !== {1'b0, 4'b0000, 2'd0}) begin errors++; $display("FAIL mid_reset: got stb=%b ack=%b grant=%0d, expected 0 0000 0", stb, ack, grant); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if ({stb, grant} !== {1'b1, 2'd1}) begin errors++; $display("FAIL mid_after: got stb=%b grant=%0d, expected 1 1", stb, grant); end
        bus_ack = 1'b1;
        tick();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL mid_ack: got ack=%b, expected 0010", ack); end
        req = '0; bus_ack = 1'b0;
        tick();
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0001; bus_rdata = 32'h77;
        for (int n = 0; n < 8; n++) tick();
        checks++; if ({stb, ack, err} !== {1'b1, 8'd0}) begin errors++; $display("FAIL to_wait: got stb=%b ack=%b err=%b, expected 1 0000 0000", stb, ack, err); end
        tick();
        checks++; if ({stb, ack, err, rdata} !== {1'b0, 4'b0001, 4'b0001, 32'h0}) begin errors++; $display("FAIL to_abort: got stb=%b ack=%b err=%b data=%h, expected 0 0001 0001 0", stb, ack, err, rdata); end
        req = '0;
        tick();
        req = 4'b0001;
        for (int n = 0; n < 8; n++) tick();
        bus_ack = 1'b1;
        tick();
        checks++; if ({ack, err, rdata} !== {4'b0001, 4'b0000, 32'h77}) begin errors++; $display("FAIL to_race: got ack=%b err=%b data=%h, expected 0001 0000 00000077", ack, err, rdata); end
        req = '0; bus_ack = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_fairness();
        test_wrap();
        test_reset_mid_bus();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
